dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer for the MEM stage's data-memory access. It turns a load or store sitting in MEM into a valid/ready request on the data bus, waits for the response, and freezes the pipeline registers while the access is in flight. It formats load data (byte select plus sign/zero extension) into `read_data_mem`, which is then latched into the MEM/WB register. It also flags misaligned and, optionally, timed-out accesses so that WB drops the register write.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: cycles allowed in REQ+WAIT before a fault (only with the macro below).
- `CNT_W`, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge (pipeline registers latch on the falling edge).
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read_mem`  in  1  load in MEM.
- `mem_write_mem`  in  1  store in MEM. Never asserted together with `mem_read_mem`.
- `funct3_mem`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `alu_result_mem`  in  32  byte address.
- `write_data_mem`  in  32  store data (rs2).
- `read_data_mem`  out  32  formatted load data.
- `stall_o`  out  1  freeze PC and the IF/ID, ID/EX and EX/MEM registers.
- `fault_o`  out  1  misaligned or timeout; WB suppresses the register write.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  request accepted.
- `bus_addr`  out  32  word address (`alu_result_mem[31:2]`, 2'b00).
- `bus_we`  out  1  1 = write.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  store data replicated across lanes (B: ×4, H: ×2).
- `bus_rsp_valid`  in  1  read data valid, or write ack.
- `bus_rdata`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset puts the FSM in IDLE and all outputs at 0.
- Access pending: `acc = mem_read_mem | mem_write_mem`.
- Misaligned: H/HU with `addr[0]=1`, or W with `addr[1:0]≠0`.
- IDLE:
  - Aligned `acc`: `stall_o=1` (combinational). At the next edge, register `bus_addr`, `bus_we`, `bus_be` and `bus_wdata`, then go to REQ.
  - Misaligned `acc`: no bus traffic. `fault_o=1` and `stall_o=0` combinationally for that cycle. `read_data_mem=0`. Stay in IDLE.
- REQ: `bus_req_valid=1`, `stall_o=1`. All bus fields are held stable. When `bus_req_ready=1`, go to WAIT.
- WAIT: `stall_o=1`.
  - On `bus_rsp_valid`, go to DONE.
  - For loads, also capture the formatted data: select the lane by `addr[1:0]`, then sign-extend (B/H) or zero-extend (BU/HU).
- DONE: `stall_o=0`. `read_data_mem` holds the captured value (0 for stores) and is valid across the falling edge. Go to IDLE unconditionally.
- `bus_be` values:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
- `bus_rsp_valid` arriving in IDLE, REQ or DONE is ignored.
- Asserting `rst_n` low mid-access: return to IDLE immediately and drop `bus_req_valid` asynchronously. Any response still outstanding is ignored.

## Timing
- Minimum stall is 3 cycles when ready and response each come in their first eligible cycle:
  - cycle 0: IDLE detects the access.
  - cycle 1: REQ, ready=1.
  - cycle 2: WAIT, rsp=1.
  - cycle 3: DONE, `stall_o=0`.
- Each extra ready-wait or response-wait cycle adds one stall cycle.
- Back-to-back accesses: the next instruction enters MEM at the falling edge in DONE. It is detected in IDLE the following cycle, so there is 1 idle cycle between requests.
- `read_data_mem` and `fault_o` are stable from the rising edge through the falling edge of their valid cycle.

## Configuration
- `DMEM_TIMEOUT_EN`:
  - Defined: a `CNT_W`-bit watchdog clears on entry to REQ and increments each cycle in REQ or WAIT. When the count reaches `TIMEOUT_CYCLES`, the FSM goes to DONE with `fault_o=1`, `read_data_mem=0` and `bus_req_valid` dropped. A later response is ignored.
  - Undefined: no counter. REQ and WAIT wait indefinitely, and `fault_o` comes from misalignment only.

## Test plan
- Reset mid-WAIT: drop `rst_n` -> `stall_o`, `bus_req_valid`, `fault_o` = 0 immediately. A subsequent `bus_rsp_valid` is ignored and the FSM stays in IDLE.
- LB at 0x1003, `bus_rdata=0x80FF_0000` with ready and response immediate -> `bus_be=4'b1000`, stall for exactly 3 cycles, `read_data_mem=0xFFFF_FF80` in DONE.
- SH at 0x2002, `write_data_mem=0x1234_ABCD`, ready delayed 2 cycles -> `bus_addr=0x2000`, `bus_be=4'b1100`, `bus_wdata=0xABCD_ABCD`, `bus_we=1`, stall for 5 cycles.
- LW at 0x3001 -> no `bus_req_valid`, `fault_o=1` for one cycle, `stall_o=0`.
- LHU at 0x4002 then LW at 0x4004 back-to-back, `bus_rdata=0xBEEF_0000` then `0xCAFE_F00D` -> outputs `0x0000_BEEF` then `0xCAFE_F00D`, exactly 1 IDLE cycle between requests.
- With `DMEM_TIMEOUT_EN` and `TIMEOUT_CYCLES=4`: LW with no response -> DONE after 4 REQ/WAIT cycles with `fault_o=1` and `read_data_mem=0`. A late `bus_rsp_valid` has no effect.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data-memory access sequencer: bus request/response, stall, load formatting, fault flag.
// Optional watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_mem,
   input  logic        mem_write_mem,
   input  logic [2:0]  funct3_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] write_data_mem,
   output logic [31:0] read_data_mem,
   output logic        stall_o,
   output logic        fault_o,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rdata
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t      state;
   logic [2:0]  fmt_q;
   logic [1:0]  off_q;
   logic [31:0] data_q;
   logic        tmo_q;
   logic        acc;
   logic        misal;
   logic        expire;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] lane;
   logic [31:0] load_fmt;

   if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TIMEOUT_CYCLES");
   end

   // Gated by rst_n so a held instruction cannot raise stall/fault during reset.
   assign acc = (mem_read_mem | mem_write_mem) & rst_n;

   always_comb begin
      misal      = 1'b0;
      be_next    = 4'b1111;
      wdata_next = write_data_mem;
      case (funct3_mem[1:0])
         2'b00: begin
            be_next    = 4'b0001 << alu_result_mem[1:0];
            wdata_next = {4{write_data_mem[7:0]}};
         end
         2'b01: begin
            misal      = alu_result_mem[0];
            be_next    = 4'b0011 << alu_result_mem[1:0];
            wdata_next = {2{write_data_mem[15:0]}};
         end
         default: misal = |alu_result_mem[1:0];
      endcase
   end

   always_comb begin
      lane = bus_rdata >> {off_q, 3'b000};
      case (fmt_q[1:0])
         2'b00:   load_fmt = {{24{~fmt_q[2] & lane[7]}}, lane[7:0]};
         2'b01:   load_fmt = {{16{~fmt_q[2] & lane[15]}}, lane[15:0]};
         default: load_fmt = lane;
      endcase
   end

`ifdef DMEM_TIMEOUT_EN
   logic [CNT_W-1:0] wdog;

   assign expire = (wdog >= CNT_W'(TIMEOUT_CYCLES - 1));

   // Held at zero while idle, so it starts from zero on entry to REQ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wdog <= '0;
      else if (state == S_REQ || state == S_WAIT)
         wdog <= wdog + 1'b1;
      else
         wdog <= '0;
   end
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         bus_addr  <= '0;
         bus_we    <= 1'b0;
         bus_be    <= '0;
         bus_wdata <= '0;
         fmt_q     <= '0;
         off_q     <= '0;
         data_q    <= '0;
         tmo_q     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               tmo_q <= 1'b0;
               if (acc && !misal) begin
                  state     <= S_REQ;
                  bus_addr  <= {alu_result_mem[31:2], 2'b00};
                  bus_we    <= mem_write_mem;
                  bus_be    <= be_next;
                  bus_wdata <= wdata_next;
                  fmt_q     <= funct3_mem;
                  off_q     <= alu_result_mem[1:0];
                  data_q    <= '0;
               end
            end
            S_REQ: begin
               if (bus_req_ready) begin
                  state <= S_WAIT;
               end else if (expire) begin
                  state <= S_DONE;
                  tmo_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (bus_rsp_valid) begin
                  state <= S_DONE;
                  if (!bus_we) data_q <= load_fmt;
               end else if (expire) begin
                  state <= S_DONE;
                  tmo_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus_req_valid = (state == S_REQ);
   assign stall_o       = (state == S_IDLE && acc && !misal) || state == S_REQ || state == S_WAIT;
   assign fault_o       = (state == S_IDLE && acc && misal) || (state == S_DONE && tmo_q);
   assign read_data_mem = (state == S_DONE) ? data_q : '0;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl with a transaction-timeline model.
module tb_dmem_access_ctrl;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read_mem, mem_write_mem;
   logic [2:0]  funct3_mem;
   logic [31:0] alu_result_mem, write_data_mem;
   logic [31:0] read_data_mem;
   logic        stall_o, fault_o;
   logic        bus_req_valid, bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rdata;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
      .funct3_mem(funct3_mem), .alu_result_mem(alu_result_mem),
      .write_data_mem(write_data_mem), .read_data_mem(read_data_mem),
      .stall_o(stall_o), .fault_o(fault_o),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   bit          chk_en = 1'b0;
   bit          e_stall, e_valid, e_fault, e_rd_chk;
   logic [31:0] e_rd, e_addr, e_wdata;
   logic        e_we;
   logic [3:0]  e_be;
   int          n_stall;
   logic [31:0] cap_addr, cap_wdata, cap_rd;
   logic [3:0]  cap_be;
   logic        cap_we, cap_fault;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("stall_o", {31'b0, stall_o}, {31'b0, e_stall});
         check("bus_req_valid", {31'b0, bus_req_valid}, {31'b0, e_valid});
         check("fault_o", {31'b0, fault_o}, {31'b0, e_fault});
         if (e_valid) begin
            check("bus_addr", bus_addr, e_addr);
            check("bus_we", {31'b0, bus_we}, {31'b0, e_we});
            check("bus_be", {28'b0, bus_be}, {28'b0, e_be});
            check("bus_wdata", bus_wdata, e_wdata);
         end
         if (e_rd_chk) begin
            check("read_data_mem", read_data_mem, e_rd);
            cap_rd    = read_data_mem;
            cap_fault = fault_o;
         end
         if (stall_o) n_stall++;
         if (bus_req_valid) begin
            cap_addr  = bus_addr;
            cap_we    = bus_we;
            cap_be    = bus_be;
            cap_wdata = bus_wdata;
         end
      end
   end

   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
      int     n   = nbytes(f3);
      int     off = int'(a % 4);
      longint m   = longint'(1) << (8 * n);
      longint v   = longint'(rdat) >> (8 * off);
      v = v % m;
      if (!f3[2] && n < 4 && v >= m / 2) v = v - m;
      return v[31:0];
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int n   = nbytes(f3);
      int off = int'(a % 4);
      int r   = ((1 << n) - 1) << off;
      return r[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      int n = nbytes(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   task automatic idle(input int n, input bit rspn);
      mem_read_mem = 0; mem_write_mem = 0; bus_req_ready = 0; bus_rsp_valid = rspn;
      e_stall = 0; e_valid = 0; e_fault = 0; e_rd_chk = 0;
      repeat (n) begin
         @(posedge clk); #1;
      end
      bus_rsp_valid = 0;
   endtask

   // Cycle k counts from the IDLE cycle that sees the instruction; T is the DONE cycle.
   task automatic access(input bit rd, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int rdly, input int sdly, input bit norsp);
      int n = nbytes(f3);
      int t;
      bit mis = (a % n) != 0;
      mem_read_mem = rd; mem_write_mem = !rd; funct3_mem = f3;
      alu_result_mem = a; write_data_mem = wd; bus_rdata = rdat;
      e_addr = {a[31:2], 2'b00}; e_we = !rd; e_be = m_be(f3, a); e_wdata = m_wdata(f3, wd);
      n_stall = 0;
      if (mis) begin
         bus_req_ready = 0; bus_rsp_valid = 0;
         e_stall = 0; e_valid = 0; e_fault = 1; e_rd_chk = 1; e_rd = 0;
         @(posedge clk); #1;
         return;
      end
      t = norsp ? 1 + TMO : 3 + rdly + sdly;
      for (int k = 0; k <= t; k++) begin
         bus_req_ready = (k == 1 + rdly);
         bus_rsp_valid = !norsp && (k == 2 + rdly + sdly || k == 0 || k == t);
         e_stall  = (k < t);
         e_valid  = (k >= 1) && (k <= 1 + rdly) && (k < t);
         e_fault  = norsp && (k == t);
         e_rd_chk = (k == t);
         e_rd     = (rd && !norsp) ? m_load(f3, a, rdat) : 32'h0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst_n = 0; mem_read_mem = 0; mem_write_mem = 0; funct3_mem = 0;
      alu_result_mem = 0; write_data_mem = 0; bus_req_ready = 0;
      bus_rsp_valid = 0; bus_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_stall", {31'b0, stall_o}, 0);
      check("rst_valid", {31'b0, bus_req_valid}, 0);
      check("rst_fault", {31'b0, fault_o}, 0);
      check("rst_rdata", read_data_mem, 0);
      check("rst_be", {28'b0, bus_be}, 0);
      check("rst_addr", bus_addr, 0);
      rst_n = 1;
      chk_en = 1;
      idle(2, 1);

      access(1, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0, 0);
      check("lb_be", {28'b0, cap_be}, 32'h8);
      check("lb_stall_cycles", n_stall, 3);
      check("lb_data", cap_rd, 32'hFFFF_FF80);
      idle(1, 0);

      access(0, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 2, 0, 0);
      check("sh_addr", cap_addr, 32'h2000);
      check("sh_be", {28'b0, cap_be}, 32'hC);
      check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
      check("sh_we", {31'b0, cap_we}, 1);
      check("sh_stall_cycles", n_stall, 5);
      check("sh_data", cap_rd, 0);

      access(1, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, 0);
      check("lw_mis_fault", {31'b0, cap_fault}, 1);
      check("lw_mis_stall", n_stall, 0);

      access(1, 3'b101, 32'h4002, 32'h0, 32'hBEEF_0000, 0, 0, 0);
      check("lhu_data", cap_rd, 32'h0000_BEEF);
      access(1, 3'b010, 32'h4004, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
      check("lw_data", cap_rd, 32'hCAFE_F00D);

      access(1, 3'b001, 32'h0006, 32'h0, 32'h8001_0000, 1, 2, 0);
      check("lh_data", cap_rd, 32'hFFFF_8001);
      check("lh_stall_cycles", n_stall, 6);
      access(0, 3'b000, 32'h7001, 32'h0000_00A5, 32'h0, 0, 1, 0);
      check("sb_be", {28'b0, cap_be}, 32'h2);
      check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
      access(1, 3'b100, 32'h8002, 32'h0, 32'h00C3_0000, 0, 0, 0);
      check("lbu_data", cap_rd, 32'h0000_00C3);
      access(0, 3'b010, 32'h9000, 32'hDEAD_BEEF, 32'h0, 1, 3, 0);
      access(0, 3'b001, 32'h2001, 32'h0, 32'h0, 0, 0, 0);
      access(1, 3'b000, 32'h0041, 32'h0, 32'h0000_7F00, 0, 0, 0);
      check("lb_pos_data", cap_rd, 32'h0000_007F);
      idle(1, 0);

      // Reset mid-REQ and mid-WAIT with the instruction still presented.
      chk_en = 0;
      mem_read_mem = 1; mem_write_mem = 0; funct3_mem = 3'b010; alu_result_mem = 32'h5000;
      bus_req_ready = 0; bus_rsp_valid = 0;
      @(posedge clk); #1;
      check("rq_pre_valid", {31'b0, bus_req_valid}, 1);
      #2 rst_n = 0;
      #1;
      check("rq_rst_valid", {31'b0, bus_req_valid}, 0);
      check("rq_rst_stall", {31'b0, stall_o}, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      bus_req_ready = 1;
      @(posedge clk); #1;
      bus_req_ready = 0;
      check("wt_pre_stall", {31'b0, stall_o}, 1);
      #2 rst_n = 0;
      #1;
      check("wt_rst_stall", {31'b0, stall_o}, 0);
      check("wt_rst_valid", {31'b0, bus_req_valid}, 0);
      check("wt_rst_fault", {31'b0, fault_o}, 0);
      mem_read_mem = 0;
      @(posedge clk); #1;
      rst_n = 1;
      chk_en = 1;
      idle(3, 1);
      access(1, 3'b010, 32'h0100, 32'h0, 32'h1234_5678, 0, 0, 0);
      check("post_rst_data", cap_rd, 32'h1234_5678);
      check("post_rst_stall", n_stall, 3);

`ifdef DMEM_TIMEOUT_EN
      access(1, 3'b010, 32'h3000, 32'h0, 32'h5555_5555, 0, 0, 1);
      check("tmo_fault", {31'b0, cap_fault}, 1);
      check("tmo_data", cap_rd, 0);
      check("tmo_stall_cycles", n_stall, 5);
      idle(2, 1);
      access(0, 3'b010, 32'h3004, 32'h1, 32'h0, 100, 0, 1);
      check("tmo_req_fault", {31'b0, cap_fault}, 1);
      idle(2, 1);
`endif
      idle(2, 0);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
